// File: rtl/uart_rx_wb.sv
// 8N1 UART receiver that delivers each received byte as a register-file write
// to a fixed destination register, with frame-error and overrun reporting.
module uart_rx_wb #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [4:0]  DEST_REG     = 5'd6
) (
    input  logic        cpu_clk,
    input  logic        rst,
    input  logic        rx_serial,
    input  logic        wr_grant,
    output logic        rx_wen,
    output logic [4:0]  rx_rd,
    output logic [31:0] rx_wdata,
    output logic        rx_busy,
    output logic        frame_err,
    output logic        overrun
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic             rx_meta;
    logic             rxs;
    logic [1:0]       state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic [7:0]       hold_reg;
    logic             pending;
    logic             stop_sample;
    logic             write_done;
    logic             accept;

    // Synchronizer flops reset high so a reset never looks like a start edge.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= 3'd0;
                    if (!rxs) begin
                        state <= START;
                    end
                end
                START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        state   <= rxs ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt   <= '0;
                        shift_reg <= {rxs, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end
                default: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign stop_sample = (state == STOP) && (clk_cnt == BIT_LAST);
    assign write_done  = pending && wr_grant;
    // A write completing on the same edge frees the holding register for the new byte.
    assign accept      = stop_sample && rxs && (!pending || write_done);

    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            hold_reg  <= 8'd0;
            pending   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_sample && !rxs;
            overrun   <= stop_sample && rxs && pending && !write_done;
            if (accept) begin
                hold_reg <= shift_reg;
                pending  <= 1'b1;
            end else if (write_done) begin
                pending  <= 1'b0;
            end
        end
    end

    assign rx_wen   = pending;
    assign rx_rd    = DEST_REG;
    assign rx_wdata = {24'd0, hold_reg};
    assign rx_busy  = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_wb.sv
// Scoreboard bench for uart_rx_wb: directed frames push expected writes/flags,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_uart_rx_wb;

    localparam int         CLKS = 4;
    localparam logic [4:0] DEST = 5'd6;

    logic        cpu_clk = 1'b0;
    logic        rst;
    logic        rx_serial;
    logic        wr_grant;
    logic        rx_wen;
    logic [4:0]  rx_rd;
    logic [31:0] rx_wdata;
    logic        rx_busy;
    logic        frame_err;
    logic        overrun;

    logic [7:0]  exp_q[$];
    int          exp_ferr = 0;
    int          exp_ovr  = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        prev_ferr = 1'b0;
    logic        prev_ovr  = 1'b0;

    uart_rx_wb #(.CLKS_PER_BIT(CLKS), .DEST_REG(DEST)) dut (
        .cpu_clk   (cpu_clk),
        .rst       (rst),
        .rx_serial (rx_serial),
        .wr_grant  (wr_grant),
        .rx_wen    (rx_wen),
        .rx_rd     (rx_rd),
        .rx_wdata  (rx_wdata),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge cpu_clk);
        #1;
    endtask

    task automatic driveBit(input logic b);
        rx_serial = b;
        waitCycles(CLKS);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(data[i]);
        driveBit(stop_bit);
        rx_serial = 1'b1;
        waitCycles(6);
    endtask

    // Monitor: completed writes and flag pulses are matched against expectations.
    always @(negedge cpu_clk) begin
        if (!rst) begin
            if (rx_wen && wr_grant) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_write", {24'd0, rx_wdata[7:0]}, 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    checkOutput("write_data", rx_wdata, {24'd0, e});
                    checkOutput("write_rd", {27'd0, rx_rd}, {27'd0, DEST});
                end
            end
            if (frame_err) begin
                checkOutput("frame_err_expected", 32'(exp_ferr > 0), 32'd1);
                checkOutput("frame_err_width", {31'd0, prev_ferr}, 32'd0);
                if (exp_ferr > 0) exp_ferr--;
            end
            if (overrun) begin
                checkOutput("overrun_expected", 32'(exp_ovr > 0), 32'd1);
                checkOutput("overrun_width", {31'd0, prev_ovr}, 32'd0);
                if (exp_ovr > 0) exp_ovr--;
            end
        end
        prev_ferr = frame_err;
        prev_ovr  = overrun;
    end

    initial begin
        logic seen_busy;
        rst       = 1'b1;
        rx_serial = 1'b1;
        wr_grant  = 1'b1;
        #12;
        checkOutput("reset_wen", {31'd0, rx_wen}, 32'd0);
        checkOutput("reset_wdata", rx_wdata, 32'd0);
        checkOutput("reset_busy", {31'd0, rx_busy}, 32'd0);
        checkOutput("reset_flags", {30'd0, frame_err, overrun}, 32'd0);
        checkOutput("reset_rd", {27'd0, rx_rd}, 32'd6);
        @(posedge cpu_clk);
        #1 rst = 1'b0;
        waitCycles(4);

        $display("[TB] valid frame 0xA5");
        exp_q.push_back(8'hA5);
        applyStimulus(8'hA5, 1'b1);
        checkOutput("a5_wen_cleared", {31'd0, rx_wen}, 32'd0);

        $display("[TB] bad stop bit 0x3C");
        exp_ferr++;
        applyStimulus(8'h3C, 1'b0);
        checkOutput("3c_no_wen", {31'd0, rx_wen}, 32'd0);

        $display("[TB] overrun 0x11 then 0x22");
        wr_grant = 1'b0;
        exp_q.push_back(8'h11);
        applyStimulus(8'h11, 1'b1);
        checkOutput("11_pending", {31'd0, rx_wen}, 32'd1);
        exp_ovr++;
        applyStimulus(8'h22, 1'b1);
        checkOutput("22_hold_kept", rx_wdata, 32'h0000_0011);
        wr_grant = 1'b1;
        waitCycles(3);
        checkOutput("11_written", {31'd0, rx_wen}, 32'd0);

        $display("[TB] one-cycle glitch");
        rx_serial = 1'b0;
        waitCycles(1);
        rx_serial = 1'b1;
        seen_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            waitCycles(1);
            if (rx_busy) seen_busy = 1'b1;
        end
        checkOutput("glitch_started", {31'd0, seen_busy}, 32'd1);
        checkOutput("glitch_idle", {31'd0, rx_busy}, 32'd0);
        checkOutput("glitch_no_wen", {31'd0, rx_wen}, 32'd0);

        $display("[TB] reset mid-frame with a byte pending");
        wr_grant = 1'b0;
        applyStimulus(8'h33, 1'b1);
        checkOutput("33_pending", {31'd0, rx_wen}, 32'd1);
        driveBit(1'b0);
        for (int i = 0; i < 3; i++) driveBit(1'b1);
        checkOutput("ff_busy", {31'd0, rx_busy}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_wen", {31'd0, rx_wen}, 32'd0);
        checkOutput("rst_wdata", rx_wdata, 32'd0);
        checkOutput("rst_busy", {31'd0, rx_busy}, 32'd0);
        checkOutput("rst_flags", {30'd0, frame_err, overrun}, 32'd0);
        rx_serial = 1'b1;
        waitCycles(3);
        rst = 1'b0;
        waitCycles(4);
        checkOutput("post_rst_wen", {31'd0, rx_wen}, 32'd0);
        wr_grant = 1'b1;
        exp_q.push_back(8'h5A);
        applyStimulus(8'h5A, 1'b1);

        $display("[TB] long write stall 0x80");
        wr_grant = 1'b0;
        exp_q.push_back(8'h80);
        applyStimulus(8'h80, 1'b1);
        for (int i = 0; i < 100; i++) begin
            checkOutput("stall_wen", {31'd0, rx_wen}, 32'd1);
            checkOutput("stall_wdata", rx_wdata, 32'h0000_0080);
            waitCycles(1);
        end
        wr_grant = 1'b1;
        waitCycles(1);
        checkOutput("stall_cleared", {31'd0, rx_wen}, 32'd0);
        waitCycles(4);

        checkOutput("writes_outstanding", 32'(exp_q.size()), 32'd0);
        checkOutput("frame_err_outstanding", 32'(exp_ferr), 32'd0);
        checkOutput("overrun_outstanding", 32'(exp_ovr), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_wb.md
UART_RX_WB -- requirements
Module: uart_rx_wb

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, cpu_clk cycles per UART bit (legal range 4..65535).
REQ-002 SHALL have parameter DEST_REG, default 5'd6, destination register index for received bytes (must be nonzero).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port cpu_clk  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port rx_serial  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-007 SHALL have port wr_grant  input  1  register-file write port available to this block this cycle.
REQ-008 SHALL have port rx_wen  output  1  write request to register file.
REQ-009 SHALL have port rx_rd  output  5  write destination, constant DEST_REG.
REQ-010 SHALL have port rx_wdata  output  32  write data, {24'b0, received byte}.
REQ-011 SHALL have port rx_busy  output  1  high whenever FSM is not IDLE.
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-013 SHALL have port overrun  output  1  one-cycle pulse when a byte is dropped.

Function
REQ-014 SHALL pass rx_serial through a 2-flop synchronizer; only the second-stage value (rxs) is used internally.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-016 IDLE -> START on rxs==0; bit counter cleared.
REQ-017 START: at count CLKS_PER_BIT/2-1 (integer division) sample rxs; 0 -> DATA with count cleared; 1 -> IDLE (false start, no flags).
REQ-018 DATA: sample rxs every CLKS_PER_BIT cycles into shift register, LSB first; after 8th sample -> STOP.
REQ-019 STOP: sample rxs after CLKS_PER_BIT cycles; then -> IDLE in the same edge.
REQ-020 Stop sample 1 and no pending byte: byte loaded into holding register, pending set on same edge; rx_wen high from next cycle.
REQ-021 Stop sample 0: byte discarded, frame_err high exactly one cycle (the cycle after the sample), pending unchanged.
REQ-022 Stop sample 1 while pending set: new byte discarded, holding register unchanged, overrun high exactly one cycle.
REQ-023 rx_wen SHALL equal pending; rx_wdata SHALL reflect holding register, stable while rx_wen high.
REQ-024 Write completes on a rising edge where rx_wen && wr_grant; pending clears on that edge.
REQ-025 Completion and a new stop-bit acceptance on the same edge: new byte SHALL be accepted (no overrun); pending stays set with new data.
REQ-026 Reception SHALL proceed independently of write-port stall; wr_grant low indefinitely holds rx_wen high with unchanged data.
REQ-027 rx_rd SHALL be DEST_REG at all times, including reset.
REQ-028 Counters SHALL be wide enough for CLKS_PER_BIT-1 without wrap.

Reset
REQ-029 rst high SHALL force, asynchronously: FSM IDLE, counters 0, shift/holding registers 0, pending 0, synchronizer flops 1.
REQ-030 During reset rx_wen=0, rx_wdata=0, rx_busy=0, frame_err=0, overrun=0.
REQ-031 Reset mid-frame SHALL abort reception with no flag pulse; after release, a line held low is treated as a new start edge.
REQ-032 Reset while pending SHALL drop the byte; no write is issued.

Verification (CLKS_PER_BIT=4, DEST_REG=6)
REQ-033 Send 0xA5 valid frame, wr_grant=1 -> rx_wen one cycle, rx_rd=6, rx_wdata=0x000000A5, no flags.
REQ-034 Send 0x3C with stop bit 0 -> frame_err one-cycle pulse, rx_wen stays 0.
REQ-035 wr_grant=0, send 0x11 then 0x22 -> overrun pulses once at second stop bit; after wr_grant=1, rx_wdata=0x00000011 written once.
REQ-036 Low glitch of 1 cycle on idle line -> FSM returns to IDLE, no rx_wen, no flags.
REQ-037 Assert rst during DATA of 0xFF frame -> all outputs 0 immediately; next valid 0x5A frame received correctly.
REQ-038 Hold wr_grant=0 for 100 cycles after 0x80 received -> rx_wen and rx_wdata=0x00000080 stable throughout; clears one cycle after grant.
